// File: rtl/sq_sched_pkg.sv
// Shared types and constants for the square-and-accumulate scheduler.
// The SQ_SAT_EN macro, when defined, selects a saturating accumulator in sq_energy_sched.
package sq_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_RESULT = 2'd3
    } sq_state_t;

    // (-128)^2 is the largest square; it needs 15 unsigned bits.
    localparam int SQ_MAX = 16384;
    localparam int SQ_W   = 15;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/sq_rr_arbiter.sv
// Combinational round-robin picker: searches from ptr+1 upward with wrap
// and returns the first requester found as one-hot and encoded grants.
module sq_rr_arbiter
    import sq_sched_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt_oh,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int i = 1; i <= N; i++) begin
            if (!any && req[(int'(ptr) + i) % N]) begin
                any                        = 1'b1;
                gnt_idx                    = IW'((int'(ptr) + i) % N);
                gnt_oh[(int'(ptr) + i) % N] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sq_energy_sched.sv
// Shares one signed-8-bit square-and-accumulate datapath among NUM_REQ requesters.
// Optional macro SQ_SAT_EN: saturating accumulator with a sticky overflow flag on m_ovf.
module sq_energy_sched
    import sq_sched_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int Z_WIDTH   = 24,
    parameter int CNT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          s_valid,
    output logic [NUM_REQ-1:0]          s_ready,
    input  logic [NUM_REQ*8-1:0]        s_data,
    input  logic [NUM_REQ-1:0]          s_last,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [Z_WIDTH-1:0]          m_sum,
    output logic [clog2(NUM_REQ)-1:0]   m_id,
    output logic [CNT_WIDTH-1:0]        m_count,
    output logic                        m_ovf
);

    localparam int IW = clog2(NUM_REQ);

    sq_state_t state_q, state_d;

    logic [IW-1:0]        grant_q, ptr_q, arb_idx;
    logic [NUM_REQ-1:0]   arb_oh;
    logic                 arb_any;
    logic [7:0]           beat_byte;
    logic                 beat_valid, beat_last, accept;
    logic signed [15:0]   beat_ext;
    logic [SQ_W-1:0]      sq_d, sq1_q;
    logic                 sq1_v;
    logic [Z_WIDTH-1:0]   acc_q;
    logic [CNT_WIDTH-1:0] count_q;

    sq_rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
        .req     (s_valid),
        .ptr     (ptr_q),
        .gnt_oh  (arb_oh),
        .gnt_idx (arb_idx),
        .any     (arb_any)
    );

    // Per-port view of the granted requester; only it ever sees s_ready.
    always_comb begin
        beat_byte  = '0;
        beat_valid = 1'b0;
        beat_last  = 1'b0;
        s_ready    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == IW'(i)) begin
                beat_byte  = s_data[8*i +: 8];
                beat_valid = s_valid[i];
                beat_last  = s_last[i];
                s_ready[i] = (state_q == ST_STREAM);
            end
        end
    end

    assign accept   = (state_q == ST_STREAM) && beat_valid;
    assign beat_ext = signed'({{8{beat_byte[7]}}, beat_byte});
    assign sq_d     = SQ_W'(beat_ext * beat_ext);

`ifdef SQ_SAT_EN
    logic [Z_WIDTH:0] acc_sum;
    logic             ovf_q;
    assign acc_sum = {1'b0, acc_q} + (Z_WIDTH+1)'(sq1_q);
`else
    logic [Z_WIDTH-1:0] acc_sum;
    assign acc_sum = acc_q + Z_WIDTH'(sq1_q);
    assign m_ovf   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // DRAIN waits until stage 1 is empty so acc_q holds the final square.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (arb_any)              state_d = ST_STREAM;
            ST_STREAM: if (accept && beat_last)  state_d = ST_DRAIN;
            ST_DRAIN:  if (!sq1_v)               state_d = ST_RESULT;
            ST_RESULT: if (m_ready)              state_d = ST_IDLE;
            default:                             state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sq1_q   <= '0;
            sq1_v   <= 1'b0;
            acc_q   <= '0;
            count_q <= '0;
            grant_q <= '0;
            ptr_q   <= IW'(NUM_REQ - 1);
            m_valid <= 1'b0;
            m_sum   <= '0;
            m_id    <= '0;
            m_count <= '0;
`ifdef SQ_SAT_EN
            ovf_q   <= 1'b0;
            m_ovf   <= 1'b0;
`endif
        end else begin
            sq1_v <= accept;
            if (accept) begin
                sq1_q   <= sq_d;
                count_q <= count_q + CNT_WIDTH'(1);
            end
            if (state_q == ST_IDLE && arb_any) begin
                grant_q <= arb_idx;
                acc_q   <= '0;
                count_q <= '0;
`ifdef SQ_SAT_EN
                ovf_q   <= 1'b0;
`endif
            end
            if (sq1_v) begin
`ifdef SQ_SAT_EN
                if (acc_sum[Z_WIDTH]) begin
                    acc_q <= '1;
                    ovf_q <= 1'b1;
                end else begin
                    acc_q <= acc_sum[Z_WIDTH-1:0];
                end
`else
                acc_q <= acc_sum;
`endif
            end
            if (state_q == ST_DRAIN && !sq1_v) begin
                m_valid <= 1'b1;
                m_sum   <= acc_q;
                m_id    <= grant_q;
                m_count <= count_q;
`ifdef SQ_SAT_EN
                m_ovf   <= ovf_q;
`endif
            end
            if (state_q == ST_RESULT && m_ready) begin
                m_valid <= 1'b0;
                ptr_q   <= grant_q;
            end
        end
    end

endmodule

// File: tb/tb_sq_energy_sched.sv
// Directed bench for sq_energy_sched: a default-width instance plus a Z_WIDTH=16
// instance sharing the same stimulus, both checked against hand-computed results.
module tb_sq_energy_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  s_valid = '0;
    logic [3:0]  s_last  = '0;
    logic [31:0] s_data  = '0;
    logic        m_ready = 1'b1;

    logic [3:0]  s_ready, s_ready16;
    logic        m_valid, m_valid16;
    logic [23:0] m_sum;
    logic [15:0] m_sum16;
    logic [1:0]  m_id, m_id16;
    logic [15:0] m_count, m_count16;
    logic        m_ovf, m_ovf16;

    int checks = 0;
    int failures = 0;
    logic [31:0] r16_sum;
    logic        r16_ovf;

    sq_energy_sched #(.NUM_REQ(4), .Z_WIDTH(24), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready), .m_sum(m_sum),
        .m_id(m_id), .m_count(m_count), .m_ovf(m_ovf)
    );

    sq_energy_sched #(.NUM_REQ(4), .Z_WIDTH(16), .CNT_WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready16), .s_data(s_data),
        .s_last(s_last), .m_valid(m_valid16), .m_ready(m_ready), .m_sum(m_sum16),
        .m_id(m_id16), .m_count(m_count16), .m_ovf(m_ovf16)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Presents one beat on requester id and returns 1ns after the accepting edge.
    task automatic send_beat(input int id, input logic [7:0] d, input logic last);
        logic acc;
        int   t;
        acc = 1'b0;
        t   = 0;
        s_valid[id]      = 1'b1;
        s_data[8*id +: 8] = d;
        s_last[id]       = last;
        while (!acc && t < 100) begin
            @(negedge clk);
            acc = s_ready[id];
            @(posedge clk);
            #1;
            t++;
        end
        check_eq("beat_accepted", {31'd0, acc}, 32'd1);
        s_valid[id] = 1'b0;
        s_last[id]  = 1'b0;
    endtask

    // Waits (bounded) for m_valid, checks the result, then lets the handshake edge pass.
    task automatic get_result(input string tag, input logic [31:0] esum, input int eid,
                              input int ecnt, input logic eovf);
        int t;
        t = 0;
        @(negedge clk);
        while (!m_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        check_eq({tag, "_valid"}, {31'd0, m_valid}, 32'd1);
        check_eq({tag, "_sum"}, {8'd0, m_sum}, esum);
        check_eq({tag, "_id"}, {30'd0, m_id}, eid);
        check_eq({tag, "_count"}, {16'd0, m_count}, ecnt);
        check_eq({tag, "_ovf"}, {31'd0, m_ovf}, {31'd0, eovf});
        r16_sum = {16'd0, m_sum16};
        r16_ovf = m_ovf16;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check_eq("rst_s_ready", {28'd0, s_ready}, 32'd0);
        check_eq("rst_m_sum", {8'd0, m_sum}, 32'd0);
        check_eq("rst_m_id", {30'd0, m_id}, 32'd0);
        check_eq("rst_m_count", {16'd0, m_count}, 32'd0);
        check_eq("rst_m_ovf", {31'd0, m_ovf}, 32'd0);
        @(posedge clk);
        #1;

        // Round robin: 0 and 2 together -> 0 first; 0 re-requests while 2 waits -> 2 next.
        fork
            begin
                send_beat(0, 8'd2, 1'b1);
                send_beat(0, 8'd3, 1'b1);
            end
            send_beat(2, 8'd2, 1'b1);
            begin
                get_result("rr_a", 32'd4, 0, 1, 1'b0);
                get_result("rr_b", 32'd4, 2, 1, 1'b0);
                get_result("rr_c", 32'd9, 0, 1, 1'b0);
            end
        join
        repeat (2) @(posedge clk);
        #1;

        // 3, -4, 5 on requester 0: 9+16+25 = 50, valid two edges after the last beat.
        send_beat(0, 8'd3, 1'b0);
        send_beat(0, 8'hFC, 1'b0);
        send_beat(0, 8'd5, 1'b1);
        @(negedge clk);
        check_eq("lat_k0", {31'd0, m_valid}, 32'd0);
        @(negedge clk);
        check_eq("lat_k1", {31'd0, m_valid}, 32'd0);
        @(negedge clk);
        check_eq("lat_k2", {31'd0, m_valid}, 32'd1);
        check_eq("basic_sum", {8'd0, m_sum}, 32'd50);
        check_eq("basic_id", {30'd0, m_id}, 32'd0);
        check_eq("basic_count", {16'd0, m_count}, 32'd3);
        @(negedge clk);
        check_eq("lat_pulse", {31'd0, m_valid}, 32'd0);
        @(posedge clk);
        #1;

        // Two maximum squares: 32768.
        send_beat(1, 8'h80, 1'b0);
        send_beat(1, 8'h80, 1'b1);
        get_result("max", 32'd32768, 1, 2, 1'b0);

        // Backpressure: result held, no s_ready, no new grant while pending.
        m_ready = 1'b0;
        send_beat(2, 8'd7, 1'b1);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!m_valid && t < 50);
        check_eq("hold_seen", {31'd0, m_valid}, 32'd1);
        s_valid[0]    = 1'b1;
        s_data[7:0]   = 8'd1;
        s_last[0]     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("hold_valid", {31'd0, m_valid}, 32'd1);
            check_eq("hold_sum", {8'd0, m_sum}, 32'd49);
            check_eq("hold_id", {30'd0, m_id}, 32'd2);
            check_eq("hold_ready", {28'd0, s_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        get_result("hold", 32'd49, 2, 1, 1'b0);
        send_beat(0, 8'd1, 1'b1);
        get_result("after_hold", 32'd1, 0, 1, 1'b0);

        // Five -128 beats: 81920 at 24 bits; 16-bit instance wraps or saturates.
        for (int i = 0; i < 5; i++) send_beat(3, 8'h80, (i == 4));
        get_result("five", 32'd81920, 3, 5, 1'b0);
`ifdef SQ_SAT_EN
        check_eq("z16_sum", r16_sum, 32'd65535);
        check_eq("z16_ovf", {31'd0, r16_ovf}, 32'd1);
`else
        check_eq("z16_sum", r16_sum, 32'd16384);
        check_eq("z16_ovf", {31'd0, r16_ovf}, 32'd0);
`endif

        // Reset mid-burst: aborted burst yields nothing; next burst is clean.
        send_beat(0, 8'd5, 1'b0);
        send_beat(0, 8'd6, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check_eq("abort_no_result", {31'd0, m_valid}, 32'd0);
        end
        check_eq("abort_s_ready", {28'd0, s_ready}, 32'd0);
        @(posedge clk);
        #1;
        send_beat(0, 8'd1, 1'b0);
        send_beat(0, 8'd1, 1'b1);
        get_result("post_rst", 32'd2, 0, 2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
